tetris_sequencer: RTL and testbench

- Central game controller for the Tetris row array.
- Broadcasts the 3-bit phase code that every row cell decodes: 000 check/idle, 001 move, 010 write, 011 shift, 100 add.
- Consumes the OR-reduced Stop/endgame flags and per-row full flags, and sequences spawn, gravity fall, lock, and line clear.
- Keeps line and piece counters for the score display.

---
 rtl/tetris_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tetris_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_sequencer.sv
// Game controller for the Tetris row array: spawn, gravity fall, lock and line clear.
// Optional soft drop is enabled by defining TETRIS_SOFT_DROP_EN (adds i_drop).
module tetris_sequencer #(
    parameter int ROWS        = 20,
    parameter int FALL_PERIOD = 25000000,
    parameter int CNT_W       = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_start,
    input  logic                                  i_stop_any,
    input  logic                                  i_endgame_any,
    input  logic [ROWS-1:0]                       i_row_full,
`ifdef TETRIS_SOFT_DROP_EN
    input  logic                                  i_drop,
`endif
    output logic [2:0]                            o_state,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_shift_row,
    output logic                                  o_busy,
    output logic                                  o_game_over,
    output logic [CNT_W-1:0]                      o_lines,
    output logic [CNT_W-1:0]                      o_pieces
);
    // state     | meaning
    // IDLE      | waiting for the first start
    // SPAWN     | add command, new piece enters
    // SPAWN_CHK | rows report endgame from the spawn
    // FALL      | gravity timer running
    // MOVE      | move command, piece steps down
    // MOVE_CHK  | rows report whether the piece stopped
    // WRITE     | write command, piece locks into rows
    // CLR_WAIT  | lets row_full settle
    // CLR_CHK   | pick bottom-most full row or spawn next
    // SHIFT     | shift command, clear one full row
    // OVER      | game ended, waiting for start
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(FALL_PERIOD);
    localparam logic [FW-1:0] FULL_THR = FW'(FALL_PERIOD - 1);

    localparam logic [2:0] PH_CHECK = 3'b000;
    localparam logic [2:0] PH_MOVE  = 3'b001;
    localparam logic [2:0] PH_WRITE = 3'b010;
    localparam logic [2:0] PH_SHIFT = 3'b011;
    localparam logic [2:0] PH_ADD   = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN, S_SPAWN_CHK, S_FALL, S_MOVE, S_MOVE_CHK,
        S_WRITE, S_CLR_WAIT, S_CLR_CHK, S_SHIFT, S_OVER
    } state_t;

    state_t           r_fsm;
    logic [2:0]       r_phase;
    logic [RW-1:0]    r_shift_row;
    logic             r_busy;
    logic             r_over;
    logic [CNT_W-1:0] r_lines;
    logic [CNT_W-1:0] r_pieces;
    logic [FW-1:0]    r_fall_cnt;
    logic [FW-1:0]    w_thr;
    logic [RW-1:0]    w_full_idx;

`ifdef TETRIS_SOFT_DROP_EN
    localparam logic [FW-1:0] DROP_THR = FW'((FALL_PERIOD >> 3) - 1);
    assign w_thr = i_drop ? DROP_THR : FULL_THR;
`else
    assign w_thr = FULL_THR;
`endif

    // Highest set index wins: the bottom-most full row is cleared first.
    always_comb begin
        w_full_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i_row_full[i]) w_full_idx = RW'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fsm       <= S_IDLE;
            r_phase     <= PH_CHECK;
            r_shift_row <= '0;
            r_busy      <= 1'b0;
            r_over      <= 1'b0;
            r_lines     <= '0;
            r_pieces    <= '0;
            r_fall_cnt  <= '0;
        end else begin
            case (r_fsm)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        r_fsm    <= S_SPAWN;
                        r_phase  <= PH_ADD;
                        r_busy   <= 1'b1;
                        r_over   <= 1'b0;
                        r_lines  <= '0;
                        r_pieces <= '0;
                    end
                end
                S_SPAWN: begin
                    if (r_pieces != '1) r_pieces <= r_pieces + 1'b1;
                    r_fsm   <= S_SPAWN_CHK;
                    r_phase <= PH_CHECK;
                end
                S_SPAWN_CHK: begin
                    if (i_endgame_any) begin
                        r_fsm  <= S_OVER;
                        r_busy <= 1'b0;
                        r_over <= 1'b1;
                    end else begin
                        r_fsm      <= S_FALL;
                        r_fall_cnt <= '0;
                    end
                end
                S_FALL: begin
                    // >= so a soft drop raised late still exits on the next cycle
                    if (r_fall_cnt >= w_thr) begin
                        r_fsm      <= S_MOVE;
                        r_phase    <= PH_MOVE;
                        r_fall_cnt <= '0;
                    end else begin
                        r_fall_cnt <= r_fall_cnt + 1'b1;
                    end
                end
                S_MOVE: begin
                    r_fsm   <= S_MOVE_CHK;
                    r_phase <= PH_CHECK;
                end
                S_MOVE_CHK: begin
                    if (i_stop_any) begin
                        r_fsm   <= S_WRITE;
                        r_phase <= PH_WRITE;
                    end else begin
                        r_fsm      <= S_FALL;
                        r_fall_cnt <= '0;
                    end
                end
                S_WRITE: begin
                    r_fsm   <= S_CLR_WAIT;
                    r_phase <= PH_CHECK;
                end
                S_CLR_WAIT: r_fsm <= S_CLR_CHK;
                S_CLR_CHK: begin
                    if (|i_row_full) begin
                        r_fsm       <= S_SHIFT;
                        r_phase     <= PH_SHIFT;
                        r_shift_row <= w_full_idx;
                    end else begin
                        r_fsm   <= S_SPAWN;
                        r_phase <= PH_ADD;
                    end
                end
                S_SHIFT: begin
                    if (r_lines != '1) r_lines <= r_lines + 1'b1;
                    r_fsm   <= S_CLR_WAIT;
                    r_phase <= PH_CHECK;
                end
                default: begin
                    r_fsm   <= S_IDLE;
                    r_phase <= PH_CHECK;
                    r_busy  <= 1'b0;
                    r_over  <= 1'b0;
                end
            endcase
        end
    end

    assign o_state     = r_phase;
    assign o_shift_row = r_shift_row;
    assign o_busy      = r_busy;
    assign o_game_over = r_over;
    assign o_lines     = r_lines;
    assign o_pieces    = r_pieces;
endmodule

// File: tb/tb_tetris_sequencer.sv
// Directed bench for tetris_sequencer: phase sequences, clears, game over, reset, saturation.
module tb_tetris_sequencer;
    localparam int ROWS = 20;
    localparam int FP   = 8;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            stop_any = 1'b0;
    logic            endgame_any = 1'b0;
    logic [ROWS-1:0] row_full = '0;
`ifdef TETRIS_SOFT_DROP_EN
    logic            drop = 1'b0;
`endif
    logic [2:0]      state;
    logic [4:0]      shift_row;
    logic            busy;
    logic            game_over;
    logic [CW-1:0]   lines;
    logic [CW-1:0]   pieces;

    int n_cmp = 0;
    int n_err = 0;

    tetris_sequencer #(.ROWS(ROWS), .FALL_PERIOD(FP), .CNT_W(CW)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_start(start),
        .i_stop_any(stop_any),
        .i_endgame_any(endgame_any),
        .i_row_full(row_full),
`ifdef TETRIS_SOFT_DROP_EN
        .i_drop(drop),
`endif
        .o_state(state),
        .o_shift_row(shift_row),
        .o_busy(busy),
        .o_game_over(game_over),
        .o_lines(lines),
        .o_pieces(pieces)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From SPAWN: SPAWN_CHK, 8 x FALL, MOVE, MOVE_CHK.
    task automatic run_to_move_chk(input string tag);
        repeat (10) tick();
        n_cmp++;
        if (state !== 3'b001) begin
            n_err++;
            $display("FAIL %s move: state=%b expected 001", tag, state);
        end
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_err++;
            $display("FAIL %s move_chk: state=%b expected 000", tag, state);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({state, shift_row, busy, game_over, lines, pieces} !== '0) begin
            n_err++;
            $display("FAIL reset_state: state=%b row=%0d busy=%b over=%b lines=%0d pieces=%0d expected all 0",
                     state, shift_row, busy, game_over, lines, pieces);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: state=%b busy=%b expected 000/0", state, busy);
        end
    endtask

    task automatic test_spawn_fall();
        logic [2:0] exp [12] = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (state !== exp[i]) begin
                n_err++;
                $display("FAIL spawn_fall[%0d]: state=%b expected %b", i, state, exp[i]);
            end
            // flags and start outside their windows must be ignored
            if (i == 2) begin
                stop_any = 1'b1;
                endgame_any = 1'b1;
                start = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (i == 10) endgame_any = 1'b0;
        end
        n_cmp++;
        if (pieces !== 4'd1 || busy !== 1'b1 || game_over !== 1'b0 || lines !== 4'd0) begin
            n_err++;
            $display("FAIL spawn_counts: pieces=%0d busy=%b over=%b lines=%0d expected 1/1/0/0",
                     pieces, busy, game_over, lines);
        end
    endtask

    task automatic test_lock_no_clear();
        logic [2:0] exp [4] = '{3'd2, 3'd0, 3'd0, 3'd4};
        row_full = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) stop_any = 1'b0;
            n_cmp++;
            if (state !== exp[i]) begin
                n_err++;
                $display("FAIL lock[%0d]: state=%b expected %b", i, state, exp[i]);
            end
        end
        n_cmp++;
        if (pieces !== 4'd1 || lines !== 4'd0) begin
            n_err++;
            $display("FAIL lock_counts: pieces=%0d lines=%0d expected 1/0", pieces, lines);
        end
    endtask

    task automatic test_single_clear();
        run_to_move_chk("single");
        stop_any = 1'b1;
        tick();
        stop_any = 1'b0;
        row_full = 20'h00001;
        tick();
        row_full = 20'h00000;
        tick();
        row_full = 20'h80000;
        tick();
        n_cmp++;
        if (state !== 3'b011 || shift_row !== 5'd19 || pieces !== 4'd2) begin
            n_err++;
            $display("FAIL single_shift: state=%b row=%0d pieces=%0d expected 011/19/2",
                     state, shift_row, pieces);
        end
        row_full = '0;
        tick();
        n_cmp++;
        if (lines !== 4'd1 || state !== 3'b000) begin
            n_err++;
            $display("FAIL single_lines: lines=%0d state=%b expected 1/000", lines, state);
        end
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b100 || shift_row !== 5'd19) begin
            n_err++;
            $display("FAIL single_respawn: state=%b row=%0d expected 100/19", state, shift_row);
        end
    endtask

    task automatic test_double_clear();
        run_to_move_chk("double");
        stop_any = 1'b1;
        tick();
        stop_any = 1'b0;
        row_full = 20'hC0000;
        tick();
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b011 || shift_row !== 5'd19) begin
            n_err++;
            $display("FAIL double_first: state=%b row=%0d expected 011/19", state, shift_row);
        end
        row_full = 20'h40000;
        tick();
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b011 || shift_row !== 5'd18 || lines !== 4'd2) begin
            n_err++;
            $display("FAIL double_second: state=%b row=%0d lines=%0d expected 011/18/2",
                     state, shift_row, lines);
        end
        row_full = '0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b100 || lines !== 4'd3 || pieces !== 4'd3) begin
            n_err++;
            $display("FAIL double_end: state=%b lines=%0d pieces=%0d expected 100/3/3",
                     state, lines, pieces);
        end
    endtask

    task automatic test_game_over();
        endgame_any = 1'b1;
        tick();
        tick();
        endgame_any = 1'b0;
        n_cmp++;
        if (state !== 3'b000 || game_over !== 1'b1 || busy !== 1'b0 ||
            pieces !== 4'd4 || lines !== 4'd3) begin
            n_err++;
            $display("FAIL over_enter: state=%b over=%b busy=%b pieces=%0d lines=%0d expected 000/1/0/4/3",
                     state, game_over, busy, pieces, lines);
        end
        tick();
        n_cmp++;
        if (state !== 3'b000 || game_over !== 1'b1) begin
            n_err++;
            $display("FAIL over_hold: state=%b over=%b expected 000/1", state, game_over);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'b100 || lines !== 4'd0 || pieces !== 4'd0 ||
            game_over !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL over_restart: state=%b lines=%0d pieces=%0d over=%b busy=%b expected 100/0/0/0/1",
                     state, lines, pieces, game_over, busy);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b000 || busy !== 1'b1 || pieces !== 4'd1) begin
            n_err++;
            $display("FAIL mid_fall: state=%b busy=%b pieces=%0d expected 000/1/1", state, busy, pieces);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({state, shift_row, busy, game_over, lines, pieces} !== '0) begin
            n_err++;
            $display("FAIL async_reset: state=%b row=%0d busy=%b over=%b lines=%0d pieces=%0d expected all 0",
                     state, shift_row, busy, game_over, lines, pieces);
        end
        #3;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: state=%b busy=%b expected 000/0", state, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'b100) begin
            n_err++;
            $display("FAIL post_reset_start: state=%b expected 100", state);
        end
    endtask

    task automatic test_saturation();
        stop_any = 1'b1;
        run_to_move_chk("sat_lines");
        tick();
        row_full = 20'h00001;
        repeat (17) begin
            tick();
            tick();
            tick();
        end
        n_cmp++;
        if (state !== 3'b011 || shift_row !== 5'd0) begin
            n_err++;
            $display("FAIL sat_shift: state=%b row=%0d expected 011/0", state, shift_row);
        end
        row_full = '0;
        tick();
        n_cmp++;
        if (lines !== 4'd15) begin
            n_err++;
            $display("FAIL lines_saturate: lines=%0d expected 15", lines);
        end
        tick();
        tick();
        repeat (16) begin
            run_to_move_chk("sat_pieces");
            repeat (4) tick();
        end
        n_cmp++;
        if (state !== 3'b100 || pieces !== 4'd15) begin
            n_err++;
            $display("FAIL pieces_saturate: state=%b pieces=%0d expected 100/15", state, pieces);
        end
        stop_any = 1'b0;
        tick();
        n_cmp++;
        if (pieces !== 4'd15 || lines !== 4'd15) begin
            n_err++;
            $display("FAIL sat_hold: pieces=%0d lines=%0d expected 15/15", pieces, lines);
        end
    endtask

`ifdef TETRIS_SOFT_DROP_EN
    task automatic test_soft_drop();
        drop = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state !== 3'b001) begin
            n_err++;
            $display("FAIL drop_move: state=%b expected 001", state);
        end
        drop = 1'b0;
        tick();
        tick();
        tick();
        tick();
        drop = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b001) begin
            n_err++;
            $display("FAIL drop_late: state=%b expected 001", state);
        end
        drop = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_spawn_fall();
        test_lock_no_clear();
        test_single_clear();
        test_double_clear();
        test_game_over();
        test_reset_mid();
        test_saturation();
`ifdef TETRIS_SOFT_DROP_EN
        test_soft_drop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
